// File: rtl/z80_wb_pkg.sv
// Shared types for the Z80 -> Wishbone bridge.
//   bridge_state_t : main FSM states
//   cyc_kind_t     : decoded Z80 bus cycle type
//   DATA_FLOAT     : value returned for failed or unmapped reads
package z80_wb_pkg;

    typedef enum logic [1:0] {IDLE, WB_REQ, HOLD} bridge_state_t;

    typedef enum logic [2:0] {INTACK, MEM_RD, MEM_WR, IO_RD, IO_WR, MAP_RD, MAP_WR} cyc_kind_t;

    localparam logic [7:0] DATA_FLOAT = 8'hFF;

    // Cycles that return data to the CPU and therefore drive D_O in HOLD.
    function automatic logic kind_is_read(input cyc_kind_t k);
        return (k == INTACK) || (k == MEM_RD) || (k == IO_RD) || (k == MAP_RD);
    endfunction

endpackage

// File: rtl/z80_wb_page_mapper.sv
// Four page registers translating A[15:14] into a PAGE_W-bit WB page.
// Resets to identity (page[i] = i).
//   clk, rst_n : clock, async active-low reset
//   we, widx, wdata : write port
//   ridx -> page    : combinational read port
module z80_wb_page_mapper #(
    parameter int PAGE_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [1:0]        widx,
    input  logic [PAGE_W-1:0] wdata,
    input  logic [1:0]        ridx,
    output logic [PAGE_W-1:0] page
);

    logic [3:0][PAGE_W-1:0] page_q, page_d;

    always_comb begin
        page_d = page_q;
        if (we) page_d[widx] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) page_q[i] <= PAGE_W'(i);
        end else begin
            page_q <= page_d;
        end
    end

    assign page = page_q[ridx];

endmodule

// File: rtl/z80_wb_bridge.sv
// Z80 pin bus -> Wishbone classic master with page mapper, IM2 vector
// response, nWAIT stretching and error/timeout termination.
//   CLK, nRESET                : clock, async active-low reset
//   A, D_I, D_O, D_OE          : Z80 address / split data bus
//   nM1..nRFSH, nWAIT          : Z80 strobes in, wait request out
//   int_vec_i                  : IM2 vector for interrupt acknowledge
//   wb_*                       : Wishbone classic master port
//   bus_err_o                  : 1-CLK pulse on WB error or timeout
module z80_wb_bridge
    import z80_wb_pkg::*;
#(
    parameter int         WB_ADR_W    = 24,
    parameter logic [7:0] MAP_PORT    = 8'hF8,
    parameter int         TIMEOUT_CYC = 256,
    parameter bit         IO_ON_WB    = 1'b1
) (
    input  logic                CLK,
    input  logic                nRESET,
    input  logic [15:0]         A,
    input  logic [7:0]          D_I,
    output logic [7:0]          D_O,
    output logic                D_OE,
    input  logic                nM1,
    input  logic                nMREQ,
    input  logic                nIORQ,
    input  logic                nRD,
    input  logic                nWR,
    input  logic                nRFSH,
    output logic                nWAIT,
    input  logic [7:0]          int_vec_i,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [WB_ADR_W-1:0] wb_adr_o,
    output logic [7:0]          wb_dat_o,
    output logic                wb_sel_o,
    output logic                wb_io_o,
    input  logic [7:0]          wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    output logic                bus_err_o
);

    localparam int PAGE_W = WB_ADR_W - 14;
    localparam int CNT_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    bridge_state_t        state_q, state_d;
    cyc_kind_t            kind_q, kind_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 cyc_q, cyc_d, we_q, we_d, sel_q, sel_d, io_q, io_d;
    logic [WB_ADR_W-1:0]  adr_q, adr_d;
    logic [7:0]           dat_q, dat_d, dout_q, dout_d;
    logic                 doe_q, doe_d, berr_q, berr_d;

    // ---- decode ----
    logic      hit;
    cyc_kind_t kind;
    logic [7:0] map_off;
    logic      map_hit;

    assign map_off = A[7:0] - MAP_PORT;
    assign map_hit = (map_off < 8'd4);

    always_comb begin
        hit  = 1'b0;
        kind = MEM_RD;
        // Refresh cycles never start anything, regardless of other strobes.
        if (nRFSH) begin
            if (!nM1 && !nIORQ)        begin hit = 1'b1; kind = INTACK; end
            else if (!nMREQ && !nRD)   begin hit = 1'b1; kind = MEM_RD; end
            else if (!nMREQ && !nWR)   begin hit = 1'b1; kind = MEM_WR; end
            else if (!nIORQ && !nRD)   begin hit = 1'b1; kind = map_hit ? MAP_RD : IO_RD; end
            else if (!nIORQ && !nWR)   begin hit = 1'b1; kind = map_hit ? MAP_WR : IO_WR; end
        end
    end

    // ---- page mapper ----
    logic              map_we;
    logic [PAGE_W-1:0] page;

    z80_wb_page_mapper #(.PAGE_W(PAGE_W)) u_mapper (
        .clk   (CLK),
        .rst_n (nRESET),
        .we    (map_we),
        .widx  (map_off[1:0]),
        .wdata (PAGE_W'(D_I)),
        .ridx  ((kind == MAP_RD) ? map_off[1:0] : A[15:14]),
        .page  (page)
    );

    // ---- termination ----
    logic timeout, err_term, term;
    assign timeout  = (cnt_q == CNT_LAST);
    // err beats ack; ack beats a coincident timeout.
    assign err_term = wb_err_i || (timeout && !wb_ack_i);
    assign term     = wb_ack_i || err_term;

    // ---- next state ----
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        io_d    = io_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        dout_d  = dout_q;
        doe_d   = doe_q;
        berr_d  = 1'b0;
        map_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    kind_d  = kind;
                    state_d = HOLD;
                    case (kind)
                        INTACK: begin dout_d = int_vec_i; doe_d = 1'b1; end
                        MAP_WR: map_we = 1'b1;
                        MAP_RD: begin dout_d = 8'(page); doe_d = 1'b1; end
                        default: begin
                            if ((kind == IO_RD || kind == IO_WR) && !IO_ON_WB) begin
                                // IO without a WB target: reads float, writes vanish.
                                if (kind == IO_RD) begin dout_d = DATA_FLOAT; doe_d = 1'b1; end
                            end else begin
                                state_d = WB_REQ;
                                cnt_d   = '0;
                                cyc_d   = 1'b1;
                                sel_d   = 1'b1;
                                we_d    = (kind == MEM_WR) || (kind == IO_WR);
                                io_d    = (kind == IO_RD) || (kind == IO_WR);
                                adr_d   = io_d ? WB_ADR_W'(A) : {page, A[13:0]};
                                dat_d   = D_I;
                            end
                        end
                    endcase
                end
            end
            WB_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (term) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 1'b0;
                    berr_d  = err_term;
                    if (kind_is_read(kind_q)) begin
                        dout_d = err_term ? DATA_FLOAT : wb_dat_i;
                        doe_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Wait for a full strobe release so a held strobe cannot re-arm.
                if (nRD && nWR && nIORQ && nMREQ) begin
                    state_d = IDLE;
                    doe_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            kind_q  <= MEM_RD;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            io_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            io_q    <= io_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            berr_q  <= berr_d;
        end
    end

    // Wait is asserted from the decode cycle itself; reset releases it at once.
    assign nWAIT     = !(nRESET && (((state_q == IDLE) && hit) || (state_q == WB_REQ)));
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_io_o   = io_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign D_O       = dout_q;
    assign D_OE      = doe_q;
    assign bus_err_o = berr_q;

endmodule

// File: tb/tb_z80_wb_bridge.sv
module tb_z80_wb_bridge;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic [15:0] A = '0;
    logic [7:0]  D_I = '0;
    logic [7:0]  D_O;
    logic        D_OE;
    logic        nM1 = 1'b1, nMREQ = 1'b1, nIORQ = 1'b1, nRD = 1'b1, nWR = 1'b1, nRFSH = 1'b1;
    logic        nWAIT;
    logic [7:0]  int_vec_i = '0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_io_o;
    logic [23:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic [7:0]  wb_dat_i = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
    logic        bus_err_o;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    z80_wb_bridge #(.WB_ADR_W(24), .MAP_PORT(8'hF8), .TIMEOUT_CYC(16), .IO_ON_WB(1'b1)) dut (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_I(D_I), .D_O(D_O), .D_OE(D_OE),
        .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
        .nWAIT(nWAIT), .int_vec_i(int_vec_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_io_o(wb_io_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .bus_err_o(bus_err_o)
    );

    task automatic release_bus();
        nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        nRESET = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got %b exp 0", wb_cyc_o); end
        checks++; if (nWAIT !== 1'b1) begin errors++; $display("FAIL reset_nwait got %b exp 1", nWAIT); end
        checks++; if ({D_OE, D_O} !== 9'h000) begin errors++; $display("FAIL reset_dout got %b/%h exp 0/00", D_OE, D_O); end
        checks++; if ({bus_err_o, wb_we_o, wb_sel_o, wb_io_o} !== 4'b0) begin errors++; $display("FAIL reset_misc got %b exp 0000", {bus_err_o, wb_we_o, wb_sel_o, wb_io_o}); end
        nRESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_mem_read();
        int wl = 0;
        A = 16'h4123; nMREQ = 1'b0; nRD = 1'b0;
        #1; if (!nWAIT) wl++;
        @(negedge CLK);
        if (!nWAIT) wl++;
        checks++; if ({wb_cyc_o, wb_stb_o, wb_sel_o, wb_we_o, wb_io_o} !== 5'b11100) begin errors++; $display("FAIL rd_ctrl got %b exp 11100", {wb_cyc_o, wb_stb_o, wb_sel_o, wb_we_o, wb_io_o}); end
        checks++; if (wb_adr_o !== 24'h004123) begin errors++; $display("FAIL rd_adr got %h exp 004123", wb_adr_o); end
        wb_dat_i = 8'h5A; wb_ack_i = 1'b1;
        @(negedge CLK);
        wb_ack_i = 1'b0;
        if (!nWAIT) wl++;
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rd_cyc_drop got %b exp 0", wb_cyc_o); end
        checks++; if ({D_OE, D_O} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rd_data got %b/%h exp 1/5a", D_OE, D_O); end
        repeat (2) begin @(negedge CLK); if (!nWAIT) wl++; end
        checks++; if (wl !== 2) begin errors++; $display("FAIL rd_wait_len got %0d exp 2", wl); end
        checks++; if ({D_OE, D_O} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL rd_data_hold got %b/%h exp 1/5a", D_OE, D_O); end
        nRD = 1'b1; nMREQ = 1'b1;
        @(negedge CLK);
        checks++; if (D_OE !== 1'b0) begin errors++; $display("FAIL rd_oe_clear got %b exp 0", D_OE); end
        release_bus();
    endtask

    task automatic test_mapper();
        int cyc_seen = 0;
        A = 16'h00F9; D_I = 8'h3C; nIORQ = 1'b0; nWR = 1'b0;
        #1;
        checks++; if (nWAIT !== 1'b0) begin errors++; $display("FAIL map_wait got %b exp 0", nWAIT); end
        repeat (3) begin @(negedge CLK); if (wb_cyc_o) cyc_seen++; end
        checks++; if (cyc_seen !== 0) begin errors++; $display("FAIL map_no_wb got %0d exp 0", cyc_seen); end
        release_bus();
        // mapper readback through IO read of the same port
        A = 16'h00F9; nIORQ = 1'b0; nRD = 1'b0;
        @(negedge CLK);
        checks++; if ({wb_cyc_o, D_OE, D_O} !== {1'b0, 1'b1, 8'h3C}) begin errors++; $display("FAIL map_rd got %b/%b/%h exp 0/1/3c", wb_cyc_o, D_OE, D_O); end
        release_bus();
        A = 16'h4010; D_I = 8'hA5; nMREQ = 1'b0; nWR = 1'b0;
        @(negedge CLK);
        checks++; if (wb_adr_o !== 24'h0F0010) begin errors++; $display("FAIL wr_adr got %h exp 0f0010", wb_adr_o); end
        checks++; if ({wb_cyc_o, wb_we_o, wb_dat_o} !== {1'b1, 1'b1, 8'hA5}) begin errors++; $display("FAIL wr_ctrl got %b/%b/%h exp 1/1/a5", wb_cyc_o, wb_we_o, wb_dat_o); end
        wb_ack_i = 1'b1;
        @(negedge CLK);
        wb_ack_i = 1'b0;
        checks++; if ({wb_cyc_o, wb_we_o, D_OE} !== 3'b000) begin errors++; $display("FAIL wr_term got %b exp 000", {wb_cyc_o, wb_we_o, D_OE}); end
        release_bus();
        // IO write to a non-mapper port reaches WB in IO space
        A = 16'h1234; D_I = 8'h11; nIORQ = 1'b0; nWR = 1'b0;
        @(negedge CLK);
        checks++; if ({wb_cyc_o, wb_io_o, wb_we_o, wb_adr_o} !== {3'b111, 24'h001234}) begin errors++; $display("FAIL io_wr got %b%b%b/%h exp 111/001234", wb_cyc_o, wb_io_o, wb_we_o, wb_adr_o); end
        wb_ack_i = 1'b1;
        @(negedge CLK);
        release_bus();
    endtask

    task automatic test_intack();
        int cyc_seen = 0;
        int_vec_i = 8'hE2; nM1 = 1'b0; nIORQ = 1'b0;
        repeat (2) begin @(negedge CLK); if (wb_cyc_o) cyc_seen++; end
        checks++; if (cyc_seen !== 0) begin errors++; $display("FAIL intack_no_wb got %0d exp 0", cyc_seen); end
        checks++; if ({D_OE, D_O} !== {1'b1, 8'hE2}) begin errors++; $display("FAIL intack_vec got %b/%h exp 1/e2", D_OE, D_O); end
        release_bus();
    endtask

    task automatic test_timeout();
        int cyc_cnt = 0;
        int err_cnt = 0;
        A = 16'h0001; nMREQ = 1'b0; nRD = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (wb_cyc_o) cyc_cnt++;
            if (bus_err_o) err_cnt++;
        end
        checks++; if (cyc_cnt !== 16) begin errors++; $display("FAIL to_len got %0d exp 16", cyc_cnt); end
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_berr got %0d exp 1", err_cnt); end
        checks++; if ({D_OE, D_O} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL to_data got %b/%h exp 1/ff", D_OE, D_O); end
        release_bus();
    endtask

    task automatic test_ack_err();
        A = 16'h8002; nMREQ = 1'b0; nRD = 1'b0;
        @(negedge CLK);
        wb_dat_i = 8'h77; wb_ack_i = 1'b1; wb_err_i = 1'b1;
        @(negedge CLK);
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        checks++; if ({wb_cyc_o, bus_err_o, D_O} !== {2'b01, 8'hFF}) begin errors++; $display("FAIL ackerr got %b%b/%h exp 01/ff", wb_cyc_o, bus_err_o, D_O); end
        @(negedge CLK);
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL ackerr_pulse got %b exp 0", bus_err_o); end
        release_bus();
    endtask

    task automatic test_back_to_back();
        int cyc_cnt = 0;
        int wl = 0;
        A = 16'h0100; nMREQ = 1'b0; nRD = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            if (wb_cyc_o) cyc_cnt++;
            wb_ack_i = wb_cyc_o;
        end
        checks++; if (cyc_cnt !== 1) begin errors++; $display("FAIL held_rd_cycles got %0d exp 1", cyc_cnt); end
        release_bus();
        cyc_cnt = 0;
        nRFSH = 1'b0; nMREQ = 1'b0; A = 16'h0042;
        for (int i = 0; i < 5; i++) begin
            #1; if (!nWAIT) wl++;
            @(negedge CLK);
            if (wb_cyc_o) cyc_cnt++;
        end
        checks++; if ({cyc_cnt, wl} !== {32'd0, 32'd0}) begin errors++; $display("FAIL rfsh got cyc %0d wait %0d exp 0 0", cyc_cnt, wl); end
        release_bus();
    endtask

    task automatic test_reset_mid();
        A = 16'h00F8; D_I = 8'h55; nIORQ = 1'b0; nWR = 1'b0;
        @(negedge CLK);
        release_bus();
        A = 16'h0010; nMREQ = 1'b0; nRD = 1'b0;
        @(negedge CLK);
        checks++; if (wb_adr_o !== 24'h154010) begin errors++; $display("FAIL pre_rst_adr got %h exp 154010", wb_adr_o); end
        nRESET = 1'b0;
        #1;
        checks++; if ({wb_cyc_o, wb_stb_o, D_OE, nWAIT} !== 4'b0001) begin errors++; $display("FAIL mid_rst got %b exp 0001", {wb_cyc_o, wb_stb_o, D_OE, nWAIT}); end
        @(negedge CLK);
        nMREQ = 1'b1; nRD = 1'b1;
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
        nMREQ = 1'b0; nRD = 1'b0;
        @(negedge CLK);
        checks++; if ({wb_cyc_o, wb_adr_o} !== {1'b1, 24'h000010}) begin errors++; $display("FAIL post_rst_adr got %b/%h exp 1/000010", wb_cyc_o, wb_adr_o); end
        wb_ack_i = 1'b1;
        @(negedge CLK);
        release_bus();
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_mapper();
        test_intack();
        test_timeout();
        test_ack_err();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
